// File: rtl/axil2apb_bridge_pkg.sv
// Shared types for the AXI4-lite to APB bridge: AXI response codes and FSM state.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bster_h;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/axil2apb_bridge_if.sv
// AXI4-lite + APB signal bundle around the bridge.
// slave modport = bridge view (AXI slave, APB master); master modport = environment view.
// Backpressure: carried by the valid/ready pairs and pready.
interface axil2apb_bridge_if #(
    parameter int CSR_ADDR_WIDTH = 8,
    parameter int CSR_DATA_WIDTH = 32
);
    logic                          awvalid, awready;
    logic [CSR_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                    awprot;
    logic                          wvalid, wready;
    logic [CSR_DATA_WIDTH-1:0]     wdata;
    logic [CSR_DATA_WIDTH/8-1:0]   wstrb;
    logic                          bvalid, bready;
    logic [1:0]                    bresp;
    logic                          arvalid, arready;
    logic [CSR_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                    arprot;
    logic                          rvalid, rready;
    logic [CSR_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                    rresp;
    logic                          psel, penable, pwrite;
    logic [CSR_ADDR_WIDTH-1:0]     paddr;
    logic [1:0]                    pprot;
    logic [CSR_DATA_WIDTH-1:0]     pwdata;
    logic [CSR_DATA_WIDTH/8-1:0]   pstrb;
    logic                          pready;
    logic [CSR_DATA_WIDTH-1:0]     prdata;
    logic                          pslverr;

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
        input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/axil2apb_bridge_hold_slot.sv
// One-entry holding slot: captures a beat on valid&&ready, holds it until clr.
// Latency: full one cycle after the accepting edge.
// Backpressure: ready is low while full (and during reset).
module axil_hold_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             clr,
    output logic             in_rdy,
    output logic             full,
    output logic [WIDTH-1:0] dat
);
    logic             full_q, full_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    assign in_rdy = ~full_q & ~rst;
    assign full   = full_q;
    assign dat    = dat_q;

    // Fill on accept; clr only arrives while full, so it never collides with a fill.
    always_comb begin
        full_d = full_q;
        dat_d  = dat_q;
        if (in_vld && in_rdy) begin
            full_d = 1'b1;
            dat_d  = in_dat;
        end else if (clr) begin
            full_d = 1'b0;
        end
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            full_q <= full_d;
            dat_q  <= dat_d;
        end
    end
endmodule

// File: rtl/axil2apb_bridge.sv
// AXI4-lite slave to APB master bridge; one APB transfer at a time, read/write round-robin.
// Latency: slots full at edge N -> SETUP N+1 -> ACCESS N+2 -> response after pready sampled.
// Backpressure: each AXI ready is low while its slot holds a beat; ACCESS waits on pready
// (bounded by TIMEOUT_CYCLES with DECERR when AXIL2APB_TIMEOUT_EN is defined).
module axil2apb_bridge
    import bster_h::*;
#(
    parameter int CSR_ADDR_WIDTH = 8,
    parameter int CSR_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic           pclk,
    input logic           preset,
    axil2apb_bridge_if.slave bus
);
    localparam int STRB_W = CSR_DATA_WIDTH / 8;
    localparam int AX_W   = CSR_ADDR_WIDTH + 3;
    localparam int W_W    = CSR_DATA_WIDTH + STRB_W;

    logic            aw_full, w_full, ar_full;
    logic [AX_W-1:0] aw_dat, ar_dat;
    logic [W_W-1:0]  w_dat;
    logic            b_vld, r_vld, wr_clr, rd_clr;
    logic            wr_pend, rd_pend;

    state_e                    state_q, state_d;
    logic                      gnt_wr_q, gnt_wr_d;
    logic                      fav_rd_q, fav_rd_d;
    logic [1:0]                resp_q, resp_d;
    logic [CSR_DATA_WIDTH-1:0] rdata_q, rdata_d;

`ifdef AXIL2APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Only axprot[1:0] reaches APB.
    logic unused_prot;
    assign unused_prot = aw_dat[2] ^ ar_dat[2];

    assign b_vld   = (state_q == ST_RESP) &&  gnt_wr_q;
    assign r_vld   = (state_q == ST_RESP) && !gnt_wr_q;
    assign wr_clr  = b_vld && bus.bready;
    assign rd_clr  = r_vld && bus.rready;
    assign wr_pend = aw_full && w_full;
    assign rd_pend = ar_full;

    axil_hold_slot #(.WIDTH(AX_W)) u_aw_slot (
        .clk(pclk), .rst(preset), .in_vld(bus.awvalid), .in_dat({bus.awaddr, bus.awprot}),
        .clr(wr_clr), .in_rdy(bus.awready), .full(aw_full), .dat(aw_dat)
    );
    axil_hold_slot #(.WIDTH(W_W)) u_w_slot (
        .clk(pclk), .rst(preset), .in_vld(bus.wvalid), .in_dat({bus.wdata, bus.wstrb}),
        .clr(wr_clr), .in_rdy(bus.wready), .full(w_full), .dat(w_dat)
    );
    axil_hold_slot #(.WIDTH(AX_W)) u_ar_slot (
        .clk(pclk), .rst(preset), .in_vld(bus.arvalid), .in_dat({bus.araddr, bus.arprot}),
        .clr(rd_clr), .in_rdy(bus.arready), .full(ar_full), .dat(ar_dat)
    );

    // State, grant, arbitration pointer and captured response registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= ST_IDLE;
            gnt_wr_q <= 1'b0;
            fav_rd_q <= 1'b0;
            resp_q   <= RESP_OKAY;
            rdata_q  <= '0;
`ifdef AXIL2APB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_wr_q <= gnt_wr_d;
            fav_rd_q <= fav_rd_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
`ifdef AXIL2APB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Next state: arbitrate in IDLE, wait for pready in ACCESS, wait for the AXI handshake in RESP.
    always_comb begin
        state_d  = state_q;
        gnt_wr_d = gnt_wr_q;
        fav_rd_d = fav_rd_q;
        resp_d   = resp_q;
        rdata_d  = rdata_q;
`ifdef AXIL2APB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (wr_pend || rd_pend) begin
                    state_d = ST_SETUP;
`ifdef AXIL2APB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (wr_pend && rd_pend) begin
                        gnt_wr_d = !fav_rd_q;
                        fav_rd_d = !fav_rd_q;
                    end else begin
                        gnt_wr_d = wr_pend;
                    end
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (bus.pready) begin
                    state_d = ST_RESP;
                    rdata_d = bus.prdata;
                    resp_d  = bus.pslverr ? RESP_SLVERR : RESP_OKAY;
`ifdef AXIL2APB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    resp_d  = RESP_DECERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                if (wr_clr || rd_clr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: APB fields come straight from the granted slot while psel is high, else 0.
    always_comb begin
        bus.psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
        bus.penable = (state_q == ST_ACCESS);
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pprot   = '0;
        bus.pwdata  = '0;
        bus.pstrb   = '0;
        if (bus.psel) begin
            bus.pwrite = gnt_wr_q;
            if (gnt_wr_q) begin
                bus.paddr  = aw_dat[AX_W-1:3];
                bus.pprot  = aw_dat[1:0];
                bus.pwdata = w_dat[W_W-1:STRB_W];
                bus.pstrb  = w_dat[STRB_W-1:0];
            end else begin
                bus.paddr  = ar_dat[AX_W-1:3];
                bus.pprot  = ar_dat[1:0];
            end
        end
        bus.bvalid = b_vld;
        bus.bresp  = b_vld ? resp_q : 2'b00;
        bus.rvalid = r_vld;
        bus.rresp  = r_vld ? resp_q : 2'b00;
        bus.rdata  = r_vld ? rdata_q : '0;
    end
endmodule
